// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: a three-state request/wait/hold engine that keeps a single imem request outstanding.
// Latency: the request is issued in REQ and the response is taken in WAIT; the instruction is offered to decode in HOLD, so one instruction takes at least 3 cycles.
// Backpressure: the fetch stalls in REQ while imem is not ready, and the output buffer stays in HOLD while decode is not ready.
module ysyx_22040237_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        fetch_fault_o,
  input  logic        inst_ready_i
);

  // A faulting fetch hands decode a NOP (addi x0,x0,0) so only the fault flag carries meaning.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  // Output buffer presented to decode.
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } obuf_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  obuf_t       obuf, obuf_nxt;

  // The handshake outputs are gated by reset and redirect, so no transfer can fire in those cycles.
  always_comb begin
    imem_req_valid = ~rst & (state == S_REQ) & ~redirect_valid;
    imem_req_addr  = pc;
    inst_valid_o   = ~rst & (state == S_HOLD) & ~redirect_valid;
    inst_o         = obuf.inst;
    pc_o           = obuf.pc;
    fetch_fault_o  = obuf.fault;
  end

  // Next-state logic. In every state a redirect wins over the normal progression.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    obuf_nxt  = obuf;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (imem_rsp_valid) begin
            // The response belongs to the old path and is discarded now, so nothing is left to drop.
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            // The stale response is still in flight; remember to discard it when it arrives.
            drop_nxt = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            obuf_nxt.inst  = imem_rsp_err ? NOP_INST : imem_rsp_data;
            obuf_nxt.pc    = pc;
            obuf_nxt.fault = imem_rsp_err;
            pc_nxt         = pc + 64'd4;
            state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (inst_ready_i) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // State registers with synchronous reset. Reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      obuf  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      obuf  <= obuf_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for ysyx_22040237_ifu: the stimulus is a linear sequence of steps with expected values computed by hand.
// Inputs change 1 time unit after each rising edge, and the outputs are sampled before the next edge.
// A failed check is counted and reported, and the run always reaches the summary line.
module tb_ysyx_22040237_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fetch_fault_o;
  logic        inst_ready_i;

  int tests_run = 0;
  int tests_failed = 0;

  ysyx_22040237_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .fetch_fault_o  (fetch_fault_o),
    .inst_ready_i   (inst_ready_i)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed stimulus
  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1234_5678;
    inst_ready_i   = 1'b1;
    tick();
    // Reset is held: the handshakes stay low and the inputs are ignored.
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid_o, 0);
    redirect_valid = 1'b0;
    tick();
    chk("rst_req_valid2", imem_req_valid, 0);
    chk("rst_inst_o", inst_o, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_fault", fetch_fault_o, 0);
    chk("rst_addr", imem_req_addr, 64'h8000_0000);

    // First fetch after reset release, with a 1-cycle memory.
    rst          = 1'b0;
    inst_ready_i = 1'b0;
    #1;
    chk("f1_req_valid", imem_req_valid, 1);
    chk("f1_addr", imem_req_addr, 64'h8000_0000);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0073;
    #1;
    chk("f1_wait_no_req", imem_req_valid, 0);
    chk("f1_wait_no_inst", inst_valid_o, 0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("f1_inst_valid", inst_valid_o, 1);
    chk("f1_inst", inst_o, 32'h0010_0073);
    chk("f1_pc", pc_o, 64'h8000_0000);
    chk("f1_fault", fetch_fault_o, 0);
    chk("f1_next_addr", imem_req_addr, 64'h8000_0004);

    // Decode stalls for 5 cycles in HOLD. A stray response must also be ignored here.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_AAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_inst", inst_o, 32'h0010_0073);
      chk("hold_pc", pc_o, 64'h8000_0000);
      chk("hold_no_req", imem_req_valid, 0);
      chk("hold_valid", inst_valid_o, 1);
    end
    imem_rsp_valid = 1'b0;
    inst_ready_i   = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    #1;
    chk("release_req_valid", imem_req_valid, 1);
    chk("release_addr", imem_req_addr, 64'h8000_0004);

    // Redirect while in WAIT; the stale response arrives 2 cycles later and is dropped.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    #1;
    chk("rw_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("rw_no_inst", inst_valid_o, 0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("rw_no_inst2", inst_valid_o, 0);
    chk("rw_req_valid", imem_req_valid, 1);
    chk("rw_addr", imem_req_addr, 64'h8000_0100);

    // Redirect in the same cycle as a WAIT response.
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rs_no_inst", inst_valid_o, 0);
    chk("rs_req_valid", imem_req_valid, 1);
    chk("rs_addr", imem_req_addr, 64'h8000_0200);

    // Redirect in REQ: no request is issued that cycle and the FSM stays in REQ.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    #1;
    chk("rr_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rr_req_valid", imem_req_valid, 1);
    chk("rr_addr", imem_req_addr, 64'h8000_0300);

    // A bus-error response delivers a NOP with the fault flag set.
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'hABCD_ABCD;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    #1;
    chk("err_valid", inst_valid_o, 1);
    chk("err_inst", inst_o, 32'h0000_0013);
    chk("err_fault", fetch_fault_o, 1);
    chk("err_pc", pc_o, 64'h8000_0300);

    // Redirect in HOLD with decode ready; no handshake takes place.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    inst_ready_i   = 1'b1;
    #1;
    chk("rh_no_inst", inst_valid_o, 0);
    tick();
    redirect_valid = 1'b0;
    inst_ready_i   = 1'b0;
    #1;
    chk("rh_req_valid", imem_req_valid, 1);
    chk("rh_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // A fetch at the top of the address space: the pc wraps to 0.
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0513;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("wrap_inst", inst_o, 32'h0000_0513);
    chk("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fault", fetch_fault_o, 0);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i   = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("wrap_req_valid", imem_req_valid, 1);
    chk("wrap_addr", imem_req_addr, 64'h0);

    // A response while in REQ, with memory not ready, is ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("req_rsp_ignored_valid", imem_req_valid, 1);
    chk("req_rsp_ignored_inst", inst_valid_o, 0);
    chk("req_rsp_ignored_addr", imem_req_addr, 64'h0);

    // Reset in WAIT abandons the request; a late response in REQ is ignored.
    imem_req_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_3333;
    #1;
    chk("mrst_req_valid", imem_req_valid, 1);
    chk("mrst_addr", imem_req_addr, 64'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("mrst_no_inst", inst_valid_o, 0);
    chk("mrst_req_valid2", imem_req_valid, 1);
    chk("mrst_inst_o", inst_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
